// File: rtl/l1_dcache_pkg.sv
// Shared types and geometry for the L1 data cache.
package l1_dcache_pkg;

    localparam int LINE_BYTES   = 16;
    localparam int OFFSET_W     = 4;
    localparam int DEF_NUM_SETS = 8;
    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_INDEX_W  = $clog2(DEF_NUM_SETS);
    localparam int DEF_TAG_W    = DEF_ADDR_W - OFFSET_W - DEF_INDEX_W;

    typedef logic [8*LINE_BYTES-1:0] lc3b_datbus;
    typedef logic [DEF_TAG_W-1:0]    lc3b_c_tag;
    typedef logic [DEF_INDEX_W-1:0]  lc3b_c_index;
    typedef logic [OFFSET_W-1:0]     lc3b_c_offset;

    typedef enum logic [1:0] {
        COMPARE   = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } l1_dcache_state_t;

endpackage

// File: rtl/l1_cache_array.sv
// Line storage: data, tag, valid and dirty per set. Async read, sync byte-masked write.
module l1_cache_array
    import l1_dcache_pkg::*;
#(
    parameter int NUM_SETS = DEF_NUM_SETS,
    parameter int TAG_W    = DEF_TAG_W,
    localparam int INDEX_W = $clog2(NUM_SETS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [INDEX_W-1:0]    index,
    input  logic [LINE_BYTES-1:0] data_mask,
    input  lc3b_datbus            data_in,
    input  logic                  load_tag,
    input  logic [TAG_W-1:0]      tag_in,
    input  logic                  load_valid,
    input  logic                  valid_in,
    input  logic                  load_dirty,
    input  logic                  dirty_in,
    output lc3b_datbus            data_out,
    output logic [TAG_W-1:0]      tag_out,
    output logic                  valid_out,
    output logic                  dirty_out
);

    lc3b_datbus         data_mem [NUM_SETS];
    logic [TAG_W-1:0]   tag_mem  [NUM_SETS];
    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;

    // Valid/dirty state bits: the only storage cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (load_valid) valid_q[index] <= valid_in;
            if (load_dirty) dirty_q[index] <= dirty_in;
        end
    end

    // Data/tag storage; writes are blocked during reset so an abandoned fill never lands.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (load_tag) tag_mem[index] <= tag_in;
            for (int b = 0; b < LINE_BYTES; b++) begin
                if (data_mask[b]) data_mem[index][8*b +: 8] <= data_in[8*b +: 8];
            end
        end
    end

    assign data_out  = data_mem[index];
    assign tag_out   = tag_mem[index];
    assign valid_out = valid_q[index];
    assign dirty_out = dirty_q[index];

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped write-back/write-allocate L1 data cache with a single-outstanding pmem port.
module l1_dcache
    import l1_dcache_pkg::*;
#(
    parameter int NUM_SETS = DEF_NUM_SETS,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [LINE_BYTES-1:0] mem_byte_en,
    input  lc3b_datbus            mem_wdata,
    output logic                  mem_resp,
    output lc3b_datbus            mem_rdata,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_W-1:0]     pmem_address,
    output lc3b_datbus            pmem_wdata,
    input  logic                  pmem_resp,
    input  lc3b_datbus            pmem_rdata
);

    localparam int INDEX_W = $clog2(NUM_SETS);
    localparam int TAG_W   = ADDR_W - OFFSET_W - INDEX_W;
    localparam int LINE_W  = ADDR_W - OFFSET_W;

    l1_dcache_state_t state_q, state_d;

    // Line address of the miss being serviced; keeps the fill consistent even if
    // the requester drops mem_req and moves its address mid-miss.
    logic [LINE_W-1:0]  miss_line_q;
    logic [LINE_W-1:0]  cur_line;
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   req_tag;
    logic               hit;
    logic               unused_offset;

    lc3b_datbus         arr_rdata;
    logic [TAG_W-1:0]   arr_tag;
    logic               arr_valid, arr_dirty;
    logic [LINE_BYTES-1:0] arr_mask;
    logic               arr_load_tag, arr_load_valid, arr_load_dirty, arr_dirty_in;
    lc3b_datbus         arr_wdata;

    assign unused_offset = ^mem_addr[OFFSET_W-1:0];
    assign cur_line      = (state_q == COMPARE) ? mem_addr[ADDR_W-1:OFFSET_W] : miss_line_q;
    assign idx           = cur_line[INDEX_W-1:0];
    assign req_tag       = cur_line[LINE_W-1:INDEX_W];
    assign hit           = arr_valid && (arr_tag == req_tag);

    // Write-merge mux: fills take the whole pmem line, CPU writes take masked wdata.
    assign arr_wdata  = (state_q == ALLOCATE) ? pmem_rdata : mem_wdata;
    assign mem_rdata  = arr_rdata;
    assign pmem_wdata = arr_rdata;

    l1_cache_array #(.NUM_SETS(NUM_SETS), .TAG_W(TAG_W)) u_array (
        .clk        (clk),
        .reset_n    (reset_n),
        .index      (idx),
        .data_mask  (arr_mask),
        .data_in    (arr_wdata),
        .load_tag   (arr_load_tag),
        .tag_in     (req_tag),
        .load_valid (arr_load_valid),
        .valid_in   (1'b1),
        .load_dirty (arr_load_dirty),
        .dirty_in   (arr_dirty_in),
        .data_out   (arr_rdata),
        .tag_out    (arr_tag),
        .valid_out  (arr_valid),
        .dirty_out  (arr_dirty)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= COMPARE;
        else          state_q <= state_d;
    end

    // Capture the missing line when leaving COMPARE.
    always_ff @(posedge clk) begin
        if (state_q == COMPARE && mem_req && !hit) miss_line_q <= mem_addr[ADDR_W-1:OFFSET_W];
    end

    // Next state, CPU response, pmem handshake and array write strobes.
    always_comb begin
        state_d        = state_q;
        mem_resp       = 1'b0;
        pmem_read      = 1'b0;
        pmem_write     = 1'b0;
        pmem_address   = {req_tag, idx, {OFFSET_W{1'b0}}};
        arr_mask       = '0;
        arr_load_tag   = 1'b0;
        arr_load_valid = 1'b0;
        arr_load_dirty = 1'b0;
        arr_dirty_in   = 1'b0;
        case (state_q)
            COMPARE: begin
                if (mem_req) begin
                    if (hit) begin
                        mem_resp = 1'b1;
                        if (mem_we) begin
                            arr_mask       = mem_byte_en;
                            arr_load_dirty = 1'b1;
                            arr_dirty_in   = 1'b1;
                        end
                    end else begin
                        state_d = arr_dirty ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {arr_tag, idx, {OFFSET_W{1'b0}}};
                if (pmem_resp) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    arr_mask       = '1;
                    arr_load_tag   = 1'b1;
                    arr_load_valid = 1'b1;
                    arr_load_dirty = 1'b1;
                    arr_dirty_in   = 1'b0;
                    state_d        = COMPARE;
                end
            end
            default: state_d = COMPARE;
        endcase
    end

endmodule

// File: tb/tb_l1_dcache.sv
// Scoreboard bench for l1_dcache: flat-memory reference model plus a per-set presence model.
module tb_l1_dcache;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         mem_req, mem_we;
    logic [15:0]  mem_addr, mem_byte_en;
    logic [127:0] mem_wdata, mem_rdata;
    logic         mem_resp;
    logic         pmem_read, pmem_write, pmem_resp;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata, pmem_rdata;

    l1_dcache dut (
        .clk(clk), .reset_n(reset_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_byte_en(mem_byte_en), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    initial forever #5 clk = ~clk;

    typedef struct { logic [127:0] rdata; int lat; int issue; } exp_t;
    typedef struct { bit we; logic [15:0] addr; logic [127:0] wdata; int dly; } pop_t;

    exp_t exp_q[$];
    pop_t pq[$];
    int   total = 0, bad = 0, cyc = 0, resp_cnt = 0;
    bit   b2b = 0;

    // Architectural memory (what the CPU should see) and lower memory (what L2 holds).
    logic [127:0] arch [logic [15:0]];
    logic [127:0] lower[logic [15:0]];
    bit           m_v[8], m_d[8];
    logic [8:0]   m_t[8];

    function automatic logic [127:0] init_line(input logic [15:0] a);
        logic [31:0] s;
        s = {16'h0, a};
        return {s * 32'h9E3779B1, (s * 32'h85EBCA77) ^ 32'h1234, s * 32'hC2B2AE3D + 32'd7, ~(s * 32'h27D4EB2F)};
    endfunction

    function automatic logic [127:0] get_arch(input logic [15:0] a);
        return arch.exists(a) ? arch[a] : init_line(a);
    endfunction

    function automatic logic [127:0] get_lower(input logic [15:0] a);
        return lower.exists(a) ? lower[a] : init_line(a);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Spec-level model of one access: decide hit/miss/victim, queue expected pmem traffic,
    // and return the line the CPU should observe plus the expected extra latency.
    task automatic model_access(input bit we, input logic [15:0] addr, input logic [15:0] be,
                                input logic [127:0] wd, input int d1, input int d2,
                                output int lat, output logic [127:0] rd);
        logic [15:0]  la, va;
        logic [2:0]   idx;
        logic [8:0]   tg;
        logic [127:0] line;
        pop_t         p;
        la  = {addr[15:4], 4'h0};
        idx = addr[6:4];
        tg  = addr[15:7];
        if (m_v[idx] && m_t[idx] == tg) begin
            lat = 0;
        end else begin
            lat = d2 + 2;
            if (m_d[idx]) begin
                va = {m_t[idx], idx, 4'h0};
                p.we = 1; p.addr = va; p.wdata = get_arch(va); p.dly = d1;
                pq.push_back(p);
                lat += d1 + 1;
            end
            p.we = 0; p.addr = la; p.wdata = '0; p.dly = d2;
            pq.push_back(p);
            m_v[idx] = 1; m_t[idx] = tg; m_d[idx] = 0;
        end
        rd = get_arch(la);
        if (we) begin
            line = rd;
            for (int b = 0; b < 16; b++) if (be[b]) line[8*b +: 8] = wd[8*b +: 8];
            arch[la] = line;
            m_d[idx] = 1;
        end
    endtask

    // Reset loses any dirty data that never reached lower memory.
    task automatic model_reset();
        logic [15:0] a;
        for (int i = 0; i < 8; i++) begin
            if (m_v[i] && m_d[i]) begin
                a = {m_t[i], i[2:0], 4'h0};
                arch[a] = get_lower(a);
            end
            m_v[i] = 0; m_d[i] = 0;
        end
    endtask

    task automatic drive(input bit we, input logic [15:0] addr, input logic [15:0] be, input logic [127:0] wd);
        mem_req = 1; mem_we = we; mem_addr = addr; mem_byte_en = be; mem_wdata = wd;
    endtask

    task automatic do_req(input bit we, input logic [15:0] addr, input logic [15:0] be, input logic [127:0] wd);
        int d1, d2, lat, start, k;
        logic [127:0] rd;
        exp_t e;
        d1 = $urandom_range(0, 3);
        d2 = $urandom_range(0, 3);
        model_access(we, addr, be, wd, d1, d2, lat, rd);
        if (!b2b) begin @(posedge clk); #1; end
        drive(we, addr, be, wd);
        e.rdata = rd; e.lat = lat; e.issue = cyc;
        exp_q.push_back(e);
        start = resp_cnt;
        k = 0;
        while (resp_cnt == start && k < 200) begin @(negedge clk); #1; k++; end
        if (resp_cnt == start) begin
            total++; bad++;
            $display("FAIL resp_timeout: got=no mem_resp exp=mem_resp for addr %h", addr);
        end
        @(posedge clk); #1;
        mem_req = 0;
    endtask

    task automatic wait_pmem_read(input string name);
        int k;
        k = 0;
        while (!pmem_read && k < 50) begin @(negedge clk); k++; end
        chk(name, pmem_read, 1'b1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every mem_resp pops one expected response.
    initial forever begin
        exp_t e;
        @(negedge clk);
        chk("pmem_exclusive", pmem_read && pmem_write, 1'b0);
        if (mem_resp) begin
            resp_cnt++;
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_resp: got=mem_resp exp=none addr=%h", mem_addr);
            end else begin
                e = exp_q.pop_front();
                chk("rdata", mem_rdata, e.rdata);
                chk("latency", cyc - e.issue, e.lat);
            end
        end
    end

    // Lower-memory responder: checks each pmem request against the model, then answers after a delay.
    initial begin
        pmem_resp = 0;
        pmem_rdata = '0;
        forever begin
            pop_t p;
            bit   ab;
            @(negedge clk);
            if (reset_n && (pmem_read || pmem_write)) begin
                if (pq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_pmem: got=%s %h exp=none", pmem_write ? "write" : "read", pmem_address);
                    p.we = pmem_write; p.addr = pmem_address; p.wdata = pmem_wdata; p.dly = 0;
                end else begin
                    p = pq.pop_front();
                    chk("pmem_write_kind", pmem_write, p.we);
                    chk("pmem_address", pmem_address, p.addr);
                    if (p.we) chk("pmem_wdata", pmem_wdata, p.wdata);
                end
                ab = 0;
                for (int k = 0; k < p.dly; k++) begin
                    @(negedge clk);
                    if (!reset_n) begin ab = 1; break; end
                end
                if (!ab) begin
                    if (p.we) lower[p.addr] = p.wdata;
                    else      pmem_rdata = get_lower(p.addr);
                    pmem_resp = 1;
                    @(posedge clk); #1;
                    pmem_resp = 0;
                end
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got=no finish exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0]   tags[4];
        int           lat, start;
        logic [127:0] rd;
        logic [15:0]  a;
        tags[0] = 9'h002; tags[1] = 9'h012; tags[2] = 9'h1A5; tags[3] = 9'h0F0;
        reset_n = 0; mem_req = 0; mem_we = 0; mem_addr = '0; mem_byte_en = '0; mem_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_mem_resp", mem_resp, 1'b0);
        chk("reset_pmem_read", pmem_read, 1'b0);
        chk("reset_pmem_write", pmem_write, 1'b0);
        @(posedge clk); #1;
        reset_n = 1;

        // 1: cold read miss; 2: read hit; 3: masked write then read-back
        do_req(0, 16'h0124, 16'h0, '0);
        do_req(0, 16'h012A, 16'h0, '0);
        do_req(1, 16'h0122, 16'h000C, {96'h0, 16'hBEEF, 16'h0});
        do_req(0, 16'h0122, 16'h0, '0);
        // 4: conflicting tag forces writeback of 0x0120 then fill of 0x0920
        do_req(0, 16'h0920, 16'h0, '0);

        // 5: reset during ALLOCATE abandons the fill
        model_access(0, 16'h0124, 16'h0, '0, 0, 30, lat, rd);
        @(posedge clk); #1;
        drive(0, 16'h0124, 16'h0, '0);
        wait_pmem_read("t5_alloc_started");
        @(posedge clk); #1;
        reset_n = 0; mem_req = 0;
        @(posedge clk);
        @(negedge clk);
        chk("t5_pmem_read_dropped", pmem_read, 1'b0);
        chk("t5_pmem_write_low", pmem_write, 1'b0);
        model_reset();
        @(posedge clk); #1;
        reset_n = 1;
        do_req(0, 16'h0124, 16'h0, '0);

        // 6: drop mem_req mid-fill; the line still installs and the retry hits
        model_access(0, 16'h3450, 16'h0, '0, 0, 8, lat, rd);
        @(posedge clk); #1;
        drive(0, 16'h3450, 16'h0, '0);
        start = resp_cnt;
        wait_pmem_read("t6_alloc_started");
        repeat (2) @(posedge clk);
        #1 mem_req = 0;
        repeat (15) @(posedge clk);
        chk("t6_no_resp", resp_cnt, start);
        chk("t6_fill_done", pq.size(), 0);
        do_req(0, 16'h3450, 16'h0, '0);

        // Random traffic over a small tag pool to force conflicts and writebacks.
        for (int n = 0; n < 300; n++) begin
            a = {tags[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
            b2b = ($urandom_range(0, 1) == 1);
            do_req($urandom_range(0, 1) == 1, a,
                   ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom),
                   {$urandom, $urandom, $urandom, $urandom});
        end
        b2b = 0;
        repeat (4) @(posedge clk);
        chk("exp_queue_drained", exp_q.size(), 0);
        chk("pmem_queue_drained", pq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
